// File: rtl/ula_assinatura.sv
// MISR response compactor for the ULA result stream: folds each accepted legal
// (controle, resultadoOp) pair into a signature and grades it against a golden value.
module ula_assinatura #(
  parameter int                      BITS_PALAVRA = 16,
  parameter logic [BITS_PALAVRA-1:0] SEMENTE      = {BITS_PALAVRA{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inicio,
  input  logic                    valido,
  output logic                    pronto,
  input  logic [4:0]              controle,
  input  logic [BITS_PALAVRA-1:0] resultadoOp,
  input  logic                    fim,
  input  logic [BITS_PALAVRA-1:0] assinatura_esperada,
  output logic [BITS_PALAVRA-1:0] assinatura,
  output logic [15:0]             contagem,
  output logic [7:0]              ilegais,
  output logic                    concluido,
  output logic                    aprovado
);
  localparam int W = BITS_PALAVRA;

  typedef enum logic [1:0] {OCIOSO, COLETA, FINAL} estado_t;

  estado_t       est, est_nxt;
  logic [W-1:0]  s_nxt, s_acc, d;
  logic [15:0]   cnt_nxt, cnt_acc;
  logic [7:0]    ileg_nxt, ileg_acc;
  logic          concl_nxt, aprov_nxt;
  logic          aceita, legal, fb;

  // Codes 1xxxx are all legal; the lower half only has a sparse legal set.
  always_comb begin
    legal = 1'b0;
    if (controle[4]) legal = 1'b1;
    else begin
      case (controle[3:0])
        4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9: legal = 1'b1;
        default:                                         legal = 1'b0;
      endcase
    end
  end

  assign pronto = (est == COLETA);
  assign aceita = valido && pronto;
  assign d      = resultadoOp ^ {{(W-5){1'b0}}, controle};
  assign fb     = assinatura[W-1] ^ assinatura[W-3] ^ assinatura[W-4] ^ assinatura[W-6];

  // Post-sample view; also what fim grades when a sample lands on the same edge.
  always_comb begin
    s_acc    = assinatura;
    cnt_acc  = contagem;
    ileg_acc = ilegais;
    if (aceita) begin
      if (legal) begin
        s_acc   = {assinatura[W-2:0], fb} ^ d;
        cnt_acc = (contagem == 16'hFFFF) ? contagem : contagem + 16'd1;
      end else begin
        ileg_acc = (ilegais == 8'hFF) ? ilegais : ilegais + 8'd1;
      end
    end
  end

  always_comb begin
    est_nxt   = est;
    s_nxt     = assinatura;
    cnt_nxt   = contagem;
    ileg_nxt  = ilegais;
    concl_nxt = concluido;
    aprov_nxt = aprovado;
    case (est)
      OCIOSO: begin
        if (inicio) begin
          est_nxt  = COLETA;
          s_nxt    = SEMENTE;
          cnt_nxt  = '0;
          ileg_nxt = '0;
        end
      end
      COLETA: begin
        if (inicio) begin
          s_nxt    = SEMENTE;
          cnt_nxt  = '0;
          ileg_nxt = '0;
        end else begin
          s_nxt    = s_acc;
          cnt_nxt  = cnt_acc;
          ileg_nxt = ileg_acc;
          if (fim) begin
            est_nxt   = FINAL;
            concl_nxt = 1'b1;
            aprov_nxt = (s_acc == assinatura_esperada) && (ileg_acc == 8'd0);
          end
        end
      end
      FINAL: begin
        if (inicio) begin
          est_nxt   = COLETA;
          s_nxt     = SEMENTE;
          cnt_nxt   = '0;
          ileg_nxt  = '0;
          concl_nxt = 1'b0;
          aprov_nxt = 1'b0;
        end
      end
      default: est_nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est        <= OCIOSO;
      assinatura <= SEMENTE;
      contagem   <= '0;
      ilegais    <= '0;
      concluido  <= 1'b0;
      aprovado   <= 1'b0;
    end else begin
      est        <= est_nxt;
      assinatura <= s_nxt;
      contagem   <= cnt_nxt;
      ilegais    <= ileg_nxt;
      concluido  <= concl_nxt;
      aprovado   <= aprov_nxt;
    end
  end
endmodule

// File: tb/tb_ula_assinatura.sv
// Randomized bench for ula_assinatura against a run-level behavioural model,
// plus directed reset, restart, same-edge fim, saturation and async-reset cases.
module tb_ula_assinatura;
  logic        clk = 1'b0, rst_n = 1'b0, inicio = 1'b0, valido = 1'b0, fim = 1'b0;
  logic [4:0]  controle = '0;
  logic [15:0] resultadoOp = '0, assinatura_esperada = '0;
  logic        pronto, concluido, aprovado;
  logic [15:0] assinatura, contagem;
  logic [7:0]  ilegais;

  int total = 0, bad = 0;

  bit          m_run, m_done, m_apr;
  logic [15:0] m_s, m_cnt;
  logic [7:0]  m_ileg;

  ula_assinatura #(.BITS_PALAVRA(16)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .valido(valido), .pronto(pronto),
    .controle(controle), .resultadoOp(resultadoOp), .fim(fim),
    .assinatura_esperada(assinatura_esperada), .assinatura(assinatura),
    .contagem(contagem), .ilegais(ilegais), .concluido(concluido), .aprovado(aprovado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ilegal(input logic [4:0] c);
    return (c == 5'd2) || (c == 5'd7) || (c >= 5'd10 && c <= 5'd15);
  endfunction

  // Taps 15,13,12,10 -> mask 16'hB400; shift left, feed parity in, xor the data word.
  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [4:0] c,
                                         input logic [15:0] r);
    logic fb;
    fb = ^(s & 16'hB400);
    return ((s << 1) | 16'(fb)) ^ r ^ 16'(c);
  endfunction

  function automatic logic [4:0] rnd_legal();
    logic [4:0] c;
    do c = 5'($urandom); while (ilegal(c));
    return c;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_apr = 0; m_s = 16'hFFFF; m_cnt = '0; m_ileg = '0;
  endtask

  task automatic model_step();
    if (m_run) begin
      if (inicio) begin
        m_s = 16'hFFFF; m_cnt = '0; m_ileg = '0;
      end else begin
        if (valido) begin
          if (ilegal(controle)) m_ileg = (m_ileg == 8'hFF) ? m_ileg : m_ileg + 8'd1;
          else begin
            m_s   = m_misr(m_s, controle, resultadoOp);
            m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
          end
        end
        if (fim) begin
          m_run = 0; m_done = 1;
          m_apr = (m_s == assinatura_esperada) && (m_ileg == 0);
        end
      end
    end else if (inicio) begin
      m_run = 1; m_done = 0; m_apr = 0;
      m_s = 16'hFFFF; m_cnt = '0; m_ileg = '0;
    end
  endtask

  task automatic chk_all();
    chk("pronto", 32'(pronto), 32'(m_run));
    chk("assinatura", 32'(assinatura), 32'(m_s));
    chk("contagem", 32'(contagem), 32'(m_cnt));
    chk("ilegais", 32'(ilegais), 32'(m_ileg));
    chk("concluido", 32'(concluido), 32'(m_done));
    if (m_done) chk("aprovado", 32'(aprovado), 32'(m_apr));
  endtask

  task automatic cyc(input bit full = 1'b1);
    model_step();
    @(posedge clk); #1;
    if (full) chk_all();
    inicio = 0; fim = 0; valido = 0;
  endtask

  task automatic amostra(input logic [4:0] c, input logic [15:0] r);
    controle = c; resultadoOp = r; valido = 1; cyc();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pronto", 32'(pronto), 0);
    chk("rst_sig", 32'(assinatura), 32'h0000FFFF);
    chk("rst_cnt", 32'(contagem), 0);
    chk("rst_ileg", 32'(ilegais), 0);
    chk("rst_concl", 32'(concluido), 0);
    chk("rst_aprov", 32'(aprovado), 0);
    @(negedge clk) rst_n = 1;

    // Samples and fim in OCIOSO are ignored.
    controle = 0; resultadoOp = 16'h1234; valido = 1; cyc();
    valido = 1; cyc();
    fim = 1; cyc();
    chk("ocioso_sig", 32'(assinatura), 32'h0000FFFF);

    // Two-sample MISR.
    inicio = 1; cyc();
    amostra(5'd0, 16'h0000);
    chk("two_s1", 32'(assinatura), 32'h0000FFFE);
    amostra(5'd1, 16'h0001);
    chk("two_s2", 32'(assinatura), 32'h0000FFFC);
    chk("two_cnt", 32'(contagem), 2);
    assinatura_esperada = 16'hFFFC; fim = 1; cyc();
    chk("two_concl", 32'(concluido), 1);
    chk("two_aprov", 32'(aprovado), 1);
    chk("two_pronto", 32'(pronto), 0);

    // Illegal code.
    inicio = 1; cyc();
    amostra(5'd2, 16'h1234);
    chk("ileg_sig", 32'(assinatura), 32'h0000FFFF);
    chk("ileg_cnt", 32'(ilegais), 1);
    assinatura_esperada = 16'hFFFF; fim = 1; cyc();
    chk("ileg_aprov", 32'(aprovado), 0);
    fim = 1; valido = 1; controle = 0; cyc();

    // fim and a sample on the same edge.
    inicio = 1; cyc();
    controle = 0; resultadoOp = 0; valido = 1; fim = 1; assinatura_esperada = 16'hFFFE; cyc();
    chk("sim_cnt", 32'(contagem), 1);
    chk("sim_aprov", 32'(aprovado), 1);

    // Restart mid-run beats the sample; restart from FINAL.
    inicio = 1; cyc();
    repeat (5) amostra(rnd_legal(), 16'($urandom));
    chk("rs_cnt5", 32'(contagem), 5);
    inicio = 1; valido = 1; controle = 0; resultadoOp = 16'hAAAA; cyc();
    chk("rs_sig", 32'(assinatura), 32'h0000FFFF);
    chk("rs_cnt", 32'(contagem), 0);
    fim = 1; cyc();
    inicio = 1; cyc();
    chk("rs_fin_concl", 32'(concluido), 0);
    chk("rs_fin_pronto", 32'(pronto), 1);

    // Random runs.
    for (int run = 0; run < 24; run++) begin
      int len;
      logic [15:0] pred;
      inicio = 1; cyc();
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) begin
        valido = ($urandom_range(0, 3) != 0);
        controle = (run % 3 == 0) ? 5'($urandom) : rnd_legal();
        resultadoOp = 16'($urandom);
        inicio = ($urandom_range(0, 59) == 0);
        fim = ($urandom_range(0, 59) == 0);
        cyc();
      end
      valido = $urandom_range(0, 1);
      controle = rnd_legal(); resultadoOp = 16'($urandom);
      pred = m_s;
      if (valido && !ilegal(controle)) pred = m_misr(m_s, controle, resultadoOp);
      assinatura_esperada = $urandom_range(0, 1) ? pred : 16'($urandom);
      fim = 1; cyc();
      valido = 1; fim = 1; cyc();
    end

    // Saturation of both counters.
    inicio = 1; cyc();
    repeat (65537) begin
      valido = 1; controle = rnd_legal(); resultadoOp = 16'($urandom); cyc(1'b0);
    end
    chk_all();
    chk("sat_cnt", 32'(contagem), 32'h0000FFFF);
    repeat (300) begin
      valido = 1; controle = 5'd7; cyc(1'b0);
    end
    chk_all();
    chk("sat_ileg", 32'(ilegais), 32'h000000FF);

    // Asynchronous reset between edges.
    inicio = 1; cyc();
    repeat (3) amostra(rnd_legal(), 16'($urandom));
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst_pronto", 32'(pronto), 0);
    chk("arst_sig", 32'(assinatura), 32'h0000FFFF);
    chk("arst_cnt", 32'(contagem), 0);
    chk("arst_concl", 32'(concluido), 0);
    @(negedge clk) rst_n = 1;
    cyc();
    inicio = 1; cyc();
    amostra(5'd0, 16'h0000);
    chk("post_rst_s1", 32'(assinatura), 32'h0000FFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ula_assinatura.md
# ula_assinatura

Response compactor for the ULA datapath. It sits on the ULA result side and accepts one (controle, resultadoOp) pair per handshake. Each accepted legal operation is folded into a multiple-input signature register (MISR). At the end of a run it compares the signature against an expected value and reports pass/fail. It is the synthesizable, self-checking counterpart to the ULA stimulus sequence, intended for BIST and post-silicon checks.

## Interface
- BITS_PALAVRA, 16, ULA word width; minimum 8.
- SEMENTE, {BITS_PALAVRA{1'b1}}, MISR seed loaded on reset and on `inicio`.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- inicio  input  1  one-cycle pulse that starts or restarts a run.
- valido  input  1  result sample valid.
- pronto  output  1  block ready to accept a sample.
- controle  input  5  ULA control code of the sample.
- resultadoOp  input  BITS_PALAVRA  ULA result of the sample.
- fim  input  1  one-cycle pulse that closes the run.
- assinatura_esperada  input  BITS_PALAVRA  golden signature, sampled when `fim` is accepted.
- assinatura  output  BITS_PALAVRA  current MISR value.
- contagem  output  16  legal samples accepted; saturates at 16'hFFFF.
- ilegais  output  8  illegal-code samples accepted; saturates at 8'hFF.
- concluido  output  1  run closed; result is valid.
- aprovado  output  1  run passed; meaningful only while `concluido`=1.

## Operation
- FSM states: OCIOSO, COLETA, FINAL. Reset state is OCIOSO.
- Reset values: pronto=0, assinatura=SEMENTE, contagem=0, ilegais=0, concluido=0, aprovado=0.
- OCIOSO
  - pronto=0.
  - `inicio` → COLETA. Loads SEMENTE and clears contagem and ilegais.
- COLETA
  - pronto=1. A sample is accepted when valido && pronto.
  - Legal codes: 00000, 00001, 00011, 00100, 00101, 00110, 01000, 01001, 10000–11111 (24 codes).
  - Illegal codes: 00010, 00111, 01010–01111 (8 codes).
  - Legal sample:
    - d = resultadoOp ^ {(BITS_PALAVRA-5)'b0, controle}.
    - fb = s[15]^s[13]^s[12]^s[10]. For BITS_PALAVRA≠16, taps are s[W-1], s[W-3], s[W-4], s[W-6].
    - s_next = {s[W-2:0], fb} ^ d.
    - contagem increments, saturating at 16'hFFFF.
  - Illegal sample: MISR unchanged; ilegais increments, saturating at 8'hFF.
  - `fim` → FINAL. On the same edge:
    - aprovado is registered as (s_final == assinatura_esperada) && (ilegais_final == 0).
    - s_final and ilegais_final include any sample accepted on that same edge.
  - `inicio` in COLETA restarts: reseed and clear counters; `inicio` takes priority over `fim` and over a sample on the same edge.
- FINAL
  - pronto=0 and concluido=1. All outputs hold.
  - `inicio` → COLETA with reseed and clear; concluido and aprovado drop to 0 on that edge.
  - `fim` is ignored.
- `valido` is ignored whenever pronto=0. `fim` is ignored in OCIOSO.
- Asserting rst_n low at any time returns immediately to the reset values. Any partial run is discarded.

## Timing
- All state is registered. pronto is decoded from state only, with no combinational path from inputs.
- Sample accepted at edge N: assinatura, contagem and ilegais reflect it after edge N.
- `fim` at edge N: concluido=1 and a valid aprovado after edge N. pronto=0 from the cycle after edge N.
- `inicio` at edge N: pronto=1 after edge N, so the first acceptable sample is at edge N+1.
- Throughput: one sample per cycle while in COLETA.

## Test plan
- Reset check: hold rst_n=0 → pronto=0, assinatura=16'hFFFF, contagem=0, ilegais=0, concluido=0. Pulse valido in OCIOSO → no change.
- Two-sample MISR:
  - Stimulus: `inicio`, then (00000, 16'h0000), then (00001, 16'h0001).
  - Required: assinatura=16'hFFFE after the first sample, 16'hFFFC after the second, contagem=2.
  - Then `fim` with assinatura_esperada=16'hFFFC → concluido=1, aprovado=1.
- Illegal code: `inicio`, then (00010, 16'h1234) → assinatura stays 16'hFFFF, ilegais=1. Then `fim` with assinatura_esperada=16'hFFFF → aprovado=0.
- Simultaneous fim and valido: `inicio`; sample (00000, 16'h0000) with `fim` on the same edge and assinatura_esperada=16'hFFFE → sample counted (contagem=1), aprovado=1.
- Restart: mid-run with contagem=5, pulse `inicio` together with valido → assinatura=16'hFFFF, contagem=0, sample discarded. Separately, `inicio` from FINAL → concluido=0, pronto=1.
- Saturation and reset mid-run:
  - 65 537 legal samples → contagem=16'hFFFF while assinatura keeps updating.
  - Drop rst_n asynchronously between edges → outputs return to reset values immediately.
